// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, sideband type and level-count helper for the multiplier back-end
package mul_pkg;
    localparam int MUL_XLEN  = 32;
    localparam int MUL_TAG_W = 5;
    typedef struct packed {
        logic                 sel_msb;
        logic [MUL_TAG_W-1:0] tag;
    } mul_side_t;
    function automatic int mul_lvls(input int npp);
        return $clog2(npp);
    endfunction
endpackage

// File: rtl/mul_add_level.sv
// mul_add_level: one registered level of the adder tree, pairwise sums plus valid/sideband
module mul_add_level import mul_pkg::*; #(
    parameter int  WIDTH  = 64,
    parameter int  N_IN   = 4,
    parameter type side_t = mul_side_t
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_valid,
    input  logic [N_IN*WIDTH-1:0]     i_data,
    input  side_t                     i_side,
    input  logic                      i_adv,
    input  logic                      i_flush,
    output logic                      o_valid,
    output logic [N_IN/2*WIDTH-1:0]   o_data,
    output side_t                     o_side
);
    localparam int N_OUT = N_IN / 2;
    logic [N_OUT*WIDTH-1:0] w_sum;
    logic                   r_valid;
    logic [N_OUT*WIDTH-1:0] r_data;
    side_t                  r_side;
    for (genvar k = 0; k < N_OUT; k++) begin : g_sum
        assign w_sum[k*WIDTH +: WIDTH] = i_data[2*k*WIDTH +: WIDTH] + i_data[(2*k+1)*WIDTH +: WIDTH];
    end
    // data only moves with a valid entry, so a bubble leaves the old sum in place
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_side  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_sum;
                r_side <= i_side;
            end
        end
    end
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_side  = r_side;
endmodule

// File: rtl/mul_reduce_pipe.sv
// mul_reduce_pipe: pops partial-product entries, reduces them in a registered adder tree
// and hands the selected result half downstream over valid/ready
module mul_reduce_pipe import mul_pkg::*; #(
    parameter int XLEN  = MUL_XLEN,
    parameter int NPP   = 4,
    parameter int TAG_W = MUL_TAG_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NPP*2*XLEN-1:0] pp_i,
    input  logic                  sel_msb_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic                  empty_i,
    output logic                  pop_o,
    input  logic                  flush_i,
    output logic [XLEN-1:0]       res_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic                  busy_o
);
    localparam int W = 2 * XLEN;
    localparam int L = mul_lvls(NPP);
    typedef struct packed {
        logic             sel_msb;
        logic [TAG_W-1:0] tag;
    } side_t;
    // all level outputs packed back to back; level j starts at word NPP-(NPP>>j)
    logic [(NPP-1)*W-1:0] w_tree;
    logic [L-1:0]         w_valid;
    logic [L:0]           w_adv;
    side_t                w_side [L];
    logic [W-1:0]         w_last;
    always_comb begin
        w_adv[L] = res_ready_i;
        for (int i = L - 1; i >= 0; i--) w_adv[i] = !w_valid[i] || w_adv[i+1];
    end
    for (genvar j = 0; j < L; j++) begin : g_lvl
        logic [(NPP>>j)*W-1:0] w_in;
        logic                  w_in_valid;
        side_t                 w_in_side;
        if (j == 0) begin : g_src
            assign w_in       = pp_i;
            assign w_in_valid = pop_o;
            assign w_in_side  = {sel_msb_i, tag_i};
        end else begin : g_src
            assign w_in       = w_tree[(NPP-(NPP>>(j-1)))*W +: (NPP>>j)*W];
            assign w_in_valid = w_valid[j-1];
            assign w_in_side  = w_side[j-1];
        end
        mul_add_level #(.WIDTH(W), .N_IN(NPP>>j), .side_t(side_t)) u_lvl (
            .clk     (clk),
            .reset_n (reset_n),
            .i_valid (w_in_valid),
            .i_data  (w_in),
            .i_side  (w_in_side),
            .i_adv   (w_adv[j]),
            .i_flush (flush_i),
            .o_valid (w_valid[j]),
            .o_data  (w_tree[(NPP-(NPP>>j))*W +: (NPP>>(j+1))*W]),
            .o_side  (w_side[j])
        );
    end
    // reset_n gates the pop so the FIFO is never drained while held in reset
    assign pop_o       = reset_n && !empty_i && w_adv[0] && !flush_i;
    assign w_last      = w_tree[(NPP-2)*W +: W];
    assign res_o       = w_side[L-1].sel_msb ? w_last[W-1:XLEN] : w_last[XLEN-1:0];
    assign tag_o       = w_side[L-1].tag;
    assign res_valid_o = w_valid[L-1];
    assign busy_o      = |w_valid;
endmodule

// File: tb/tb_mul_reduce_pipe.sv
// tb_mul_reduce_pipe: scoreboard bench, driver pushes expected results, negedge monitor compares
module tb_mul_reduce_pipe;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [255:0] pp_i = '0;
    logic         sel_msb_i = 1'b0;
    logic [4:0]   tag_i = '0;
    logic         empty_i = 1'b1;
    logic         pop_o;
    logic         flush_i = 1'b0;
    logic [31:0]  res_o;
    logic [4:0]   tag_o;
    logic         res_valid_o;
    logic         res_ready_i = 1'b1;
    logic         busy_o;

    mul_reduce_pipe #(.XLEN(32), .NPP(4), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .pp_i(pp_i), .sel_msb_i(sel_msb_i), .tag_i(tag_i),
        .empty_i(empty_i), .pop_o(pop_o), .flush_i(flush_i), .res_o(res_o), .tag_o(tag_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_acc = 0;
    int          last_acc_cyc = 0;
    int          last_pop_cyc = 0;
    logic [36:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [255:0] mk(input logic [63:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] model(input logic [255:0] pp, input logic sel);
        logic [63:0] s = '0;
        for (int k = 0; k < 4; k++) s += pp[k*64 +: 64];
        return sel ? s[63:32] : s[31:0];
    endfunction

    // monitor: hold rule and in-order result comparison
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(res_valid_o), 64'd1);
                chk("hold_res", 64'(res_o), 64'(prev_res));
                chk("hold_tag", 64'(tag_o), 64'(prev_tag));
            end
            prev_stall = res_valid_o && !res_ready_i && !flush_i;
            prev_res   = res_o;
            prev_tag   = tag_o;
            if (res_valid_o && res_ready_i && !flush_i) begin
                n_acc++;
                last_acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(res_o), 64'hDEAD);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    chk("res", 64'(res_o), 64'(e[36:5]));
                    chk("tag", 64'(tag_o), 64'(e[4:0]));
                end
            end
        end
    end

    task automatic offer(input logic [255:0] pp, input logic sel, input logic [4:0] tag, input logic [31:0] exp_res);
        int t = 0;
        pp_i = pp; sel_msb_i = sel; tag_i = tag; empty_i = 1'b0;
        @(negedge clk);
        while (!pop_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!pop_o) chk("pop_timeout", 64'd0, 64'd1);
        else begin
            exp_q.push_back({exp_res, tag});
            last_pop_cyc = cyc;
        end
        @(posedge clk); #1;
        empty_i = 1'b1;
    endtask

    initial begin
        int first_pop, acc_before;
        logic [255:0] pp;
        #2 empty_i = 1'b0;
        #10;
        chk("rst_pop", 64'(pop_o), 64'd0);
        chk("rst_valid", 64'(res_valid_o), 64'd0);
        chk("rst_res", 64'(res_o), 64'd0);
        chk("rst_tag", 64'(tag_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        empty_i = 1'b1;
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        offer(mk(1, 2, 3, 4), 1'b0, 5'd7, 32'd10);
        repeat (3) @(posedge clk); #1;
        chk("latency", 64'(last_acc_cyc - last_pop_cyc), 64'd2);

        offer(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1_0000_0000, 64'd0), 1'b1, 5'd3, 32'h1);
        offer(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1_0000_0000, 64'd0), 1'b0, 5'd4, 32'h0);
        repeat (4) @(posedge clk); #1;

        acc_before = n_acc;
        first_pop = 0;
        for (int i = 0; i < 8; i++) begin
            pp = mk(64'(i) * 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0001 * 64'(i + 1),
                    64'h8000_0000_0000_0000 >> i, 64'(i * 3));
            offer(pp, i[0], 5'(i + 16), model(pp, i[0]));
            if (i == 0) first_pop = last_pop_cyc;
        end
        repeat (4) @(posedge clk); #1;
        chk("stream_pops", 64'(last_pop_cyc - first_pop), 64'd7);
        chk("stream_count", 64'(n_acc - acc_before), 64'd8);
        chk("stream_gap", 64'(last_acc_cyc - last_pop_cyc), 64'd2);

        res_ready_i = 1'b0;
        offer(mk(5, 6, 7, 8), 1'b0, 5'd1, 32'd26);
        offer(mk(64'h3_0000_0000, 64'h2_0000_0000, 0, 0), 1'b1, 5'd2, 32'd5);
        pp_i = mk(9, 9, 9, 9); sel_msb_i = 1'b0; tag_i = 5'd3; empty_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("full_no_pop", 64'(pop_o), 64'd0);
        end
        chk("full_res", 64'(res_o), 64'd26);
        @(posedge clk); #1;
        acc_before = n_acc;
        res_ready_i = 1'b1;
        offer(mk(9, 9, 9, 9), 1'b0, 5'd3, 32'd36);
        repeat (3) @(posedge clk); #1;
        chk("bp_drain", 64'(n_acc - acc_before), 64'd3);

        res_ready_i = 1'b0;
        offer(mk(100, 0, 0, 0), 1'b0, 5'd8, 32'd100);
        @(posedge clk); #1;
        pp_i = mk(1, 1, 1, 1); sel_msb_i = 1'b0; tag_i = 5'd9; empty_i = 1'b0;
        @(negedge clk);
        chk("bubble_pop", 64'(pop_o), 64'd1);
        chk("bubble_stalled", 64'(res_valid_o), 64'd1);
        if (pop_o) exp_q.push_back({32'd4, 5'd9});
        @(posedge clk); #1;
        empty_i = 1'b1;
        res_ready_i = 1'b1;
        repeat (3) @(posedge clk); #1;

        res_ready_i = 1'b0;
        offer(mk(20, 0, 0, 0), 1'b0, 5'd10, 32'd20);
        offer(mk(21, 0, 0, 0), 1'b0, 5'd11, 32'd21);
        flush_i = 1'b1; res_ready_i = 1'b1;
        pp_i = mk(22, 0, 0, 0); tag_i = 5'd12; empty_i = 1'b0;
        @(negedge clk);
        chk("flush_pop", 64'(pop_o), 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; empty_i = 1'b1;
        exp_q.delete();
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_valid", 64'(res_valid_o), 64'd0);
        acc_before = n_acc;
        repeat (3) @(posedge clk); #1;
        chk("flush_no_result", 64'(n_acc - acc_before), 64'd0);

        offer(mk(11, 0, 0, 0), 1'b0, 5'd5, 32'd11);
        offer(mk(12, 0, 0, 0), 1'b0, 5'd6, 32'd12);
        pp_i = mk(13, 0, 0, 0); empty_i = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_pop", 64'(pop_o), 64'd0);
        chk("mid_rst_valid", 64'(res_valid_o), 64'd0);
        chk("mid_rst_res", 64'(res_o), 64'd0);
        chk("mid_rst_tag", 64'(tag_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        exp_q.delete();
        empty_i = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        acc_before = n_acc;
        offer(mk(2, 2, 2, 2), 1'b0, 5'd6, 32'd8);
        repeat (3) @(posedge clk); #1;
        chk("post_rst_count", 64'(n_acc - acc_before), 64'd1);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_reduce_pipe.md
Name: mul_reduce_pipe

Overview:
- Parametrised partial-product reduction back-end of the multiplier, sitting between the multiplier partial-product FIFO (X1) and writeback.
- Pops one entry of NPP partial products (each 2*XLEN bits) from the upstream FIFO and sums them in a registered binary adder tree, one level per cycle.
- Selects the high or low XLEN half of the sum and delivers it with a tag over a valid/ready interface.
- Supports backpressure with bubble collapsing, and a synchronous flush.

Parameters:
- XLEN, 32, operand width; sum width is 2*XLEN.
- NPP, 4, number of partial products per entry; power of two, >= 2.
- TAG_W, 5, width of the opaque tag (e.g. destination register) carried alongside.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- pp_i  in  NPP*2*XLEN  partial products from the FIFO head; slice k = pp_i[k*2*XLEN +: 2*XLEN].
- sel_msb_i  in  1  1: result is sum[2*XLEN-1:XLEN]; 0: result is sum[XLEN-1:0].
- tag_i  in  TAG_W  tag of the FIFO head entry.
- empty_i  in  1  upstream FIFO empty.
- pop_o  out  1  pops the FIFO head this cycle; the entry is captured on the same edge.
- flush_i  in  1  synchronous kill of all in-flight entries.
- res_o  out  XLEN  selected result half.
- tag_o  out  TAG_W  tag of res_o.
- res_valid_o  out  1  res_o/tag_o valid.
- res_ready_i  in  1  consumer accepts when res_valid_o && res_ready_i.
- busy_o  out  1  OR of all stage valid bits.

Behaviour:
- Reset: every stage valid bit, data register and sideband register is cleared to 0. Outputs pop_o=0, res_valid_o=0, res_o=0, tag_o=0, busy_o=0. Reset takes effect immediately and asynchronously, including mid-operation; in-flight entries are lost, and the FIFO is not popped again until reset_n deasserts.
- Pipeline: L = log2(NPP) register levels. Level j holds NPP>>(j+1) partial sums of 2*XLEN bits, plus a valid bit, sel_msb and tag.
- Level 0 registers the pairwise sums of pp_i. Each later level registers the pairwise sums of the previous level.
- All additions are unsigned modulo 2^(2*XLEN), so carries out of bit 2*XLEN-1 are discarded. Signed products arrive already sign-extended from upstream; this block does not sign-extend.
- Latency: a pop in cycle t gives res_valid_o=1 in cycle t+L if no stall occurs. Sustained throughput is one entry per cycle.
- Stage advance: adv_j = !valid_j || adv_(j+1), with adv_L = res_ready_i. A stage whose adv is 0 holds its data and sideband.
- Bubble collapsing: an empty stage always accepts, even while a later stage is stalled.
- pop_o = !empty_i && adv_0 && !flush_i. Level 0 loads pp_i and its sideband only when pop_o=1; otherwise, if adv_0 is 1, it loads valid=0.
- Output: res_valid_o = valid_(L-1). res_o = sel_msb ? sum[2*XLEN-1:XLEN] : sum[XLEN-1:0], taken from the final level. The output is registered and combinationally derived from the last stage only; it has no combinational path from pp_i.
- Hold rule: while res_valid_o=1 and res_ready_i=0, res_o and tag_o stay stable.
- Full pipeline: with all L stages valid and res_ready_i=0, pop_o=0 even when empty_i=0.
- Simultaneous accept and pop: when the output is accepted and pop_o=1 in the same cycle, both take effect and no bubble is inserted.
- Flush: on the next edge, flush_i=1 clears every valid bit. During the flush cycle pop_o=0 and the output handshake is ignored; the entry presented that cycle is discarded. Flush has priority over pop and over ready.
- busy_o = OR of valid_j, over j = 0 to L-1.

Decomposition:
- Shared package mul_pkg:
  - XLEN default constant.
  - Typedef mul_side_t, a struct of {sel_msb, tag}.
  - clog2-based helper constant MUL_LVLS(NPP).
- Sub-module mul_add_level, instantiated L times through a generate loop. Parameters: WIDTH, N_IN.
  - Performs the pairwise addition for one level.
  - Holds the valid/data/sideband registers for that level and applies the adv/flush logic.

Test Plan (XLEN=32, NPP=4, L=2):
- Basic: pp={1,2,3,4}, sel_msb=0, tag=7, res_ready=1 → pop_o=1 at t, then res_o=10, tag_o=7, res_valid_o=1 at t+2.
- High half and wrap: pp={0xFFFF_FFFF_FFFF_FFFF, 1, 0x1_0000_0000, 0}, sel_msb=1 → sum=0x1_0000_0000, res_o=0x1. Same entry with sel_msb=0 → res_o=0.
- Streaming: 8 back-to-back entries with res_ready=1 → 8 pops in 8 consecutive cycles, results in order with no gaps.
- Backpressure: res_ready=0 while feeding → after 2 pops, pop_o=0 and res_o is held stable. Raise ready → one result per cycle, none lost or duplicated.
- Bubble collapse: one entry stalled at the output and level 0 empty → the next entry is popped immediately.
- Flush / reset: flush_i with 2 entries in flight → busy_o=0 next cycle, no result emitted, no pop that cycle. Assert reset_n=0 mid-stream → all outputs 0 immediately; after release the first pop yields a correct result.
